// File: rtl/fare_collector.sv
// fare_collector: payment stage for one exit lane.
// Accepts the fare from the parking controller, collects coins, returns
// change (or a full refund on cancel), opens the exit gate and keeps a
// running revenue total.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   fare_in/fare_valid  fare due for the exiting vehicle (accepted in IDLE)
//   coin_valid/coin_type coin strobe; 00=1, 01=5, 10=10, 11=20
//   cancel              driver abort request (COLLECT only)
//   busy, state         FSM status (IDLE=0 COLLECT=1 CHANGE=2 OPEN=3 REFUND=4)
//   paid                amount inserted in the current transaction
//   change/change_valid change or refund amount with one-cycle strobe
//   gate_open           exit barrier open for GATE_CYCLES cycles
//   coin_reject         coin arrived outside COLLECT and was returned
//   total_collected     accumulated fares, wraps modulo 2^TOTAL_W
//
// Optional feature: define PAYMENT_TIMEOUT_EN to build an idle-coin timeout
// in COLLECT (TIMEOUT_CYCLES without a coin behaves like cancel).
module fare_collector #(
    parameter int unsigned GATE_CYCLES    = 8,
    parameter int unsigned TOTAL_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         fare_in,
    input  logic               fare_valid,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    input  logic               cancel,
    output logic               busy,
    output logic [2:0]         state,
    output logic [10:0]        paid,
    output logic [10:0]        change,
    output logic               change_valid,
    output logic               gate_open,
    output logic               coin_reject,
    output logic [TOTAL_W-1:0] total_collected
);

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_COLLECT = 3'b001;
    localparam logic [2:0] S_CHANGE  = 3'b010;
    localparam logic [2:0] S_OPEN    = 3'b011;
    localparam logic [2:0] S_REFUND  = 3'b100;

    localparam int unsigned GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GATE_CYCLES - 1);

    logic [9:0]      due;
    logic [GC_W-1:0] gate_cnt;
    logic [10:0]     coin_amt;
    logic [10:0]     paid_sum;
    logic            timeout_hit;

    always_comb begin
        coin_amt = '0;
        unique case (coin_type)
            2'b00: coin_amt = 11'd1;
            2'b01: coin_amt = 11'd5;
            2'b10: coin_amt = 11'd10;
            2'b11: coin_amt = 11'd20;
        endcase
    end

    // paid < due <= 1023 while collecting, so paid + 20 always fits 11 bits.
    assign paid_sum = paid + coin_amt;

`ifdef PAYMENT_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;

    // Counter is held at zero outside COLLECT, so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (reset || state != S_COLLECT || coin_valid) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TO_LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // A coin in the expiry cycle wins over the timeout.
    assign timeout_hit = (state == S_COLLECT) && !coin_valid && (idle_cnt == TO_LAST);
`else
    // TIMEOUT_CYCLES only matters when the timeout counter is built.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            paid            <= '0;
            change          <= '0;
            change_valid    <= 1'b0;
            gate_open       <= 1'b0;
            coin_reject     <= 1'b0;
            total_collected <= '0;
            due             <= '0;
            gate_cnt        <= '0;
        end else begin
            change_valid <= 1'b0;
            coin_reject  <= coin_valid && (state != S_COLLECT);

            case (state)
                S_IDLE: begin
                    if (fare_valid) begin
                        due  <= fare_in;
                        paid <= '0;
                        busy <= 1'b1;
                        if (fare_in == '0) begin
                            state     <= S_OPEN;
                            gate_open <= 1'b1;
                            gate_cnt  <= '0;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end

                // change/total are registered on the way into CHANGE/REFUND so
                // they line up with the one cycle spent in those states.
                S_COLLECT: begin
                    if (coin_valid) begin
                        paid <= paid_sum;
                    end
                    if (cancel || timeout_hit) begin
                        state        <= S_REFUND;
                        change       <= coin_valid ? paid_sum : paid;
                        change_valid <= 1'b1;
                    end else if (coin_valid && paid_sum >= {1'b0, due}) begin
                        state           <= S_CHANGE;
                        change          <= paid_sum - {1'b0, due};
                        change_valid    <= 1'b1;
                        total_collected <= total_collected + TOTAL_W'(due);
                    end
                end

                S_CHANGE: begin
                    state     <= S_OPEN;
                    gate_open <= 1'b1;
                    gate_cnt  <= '0;
                end

                S_OPEN: begin
                    if (gate_cnt == GC_LAST) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        gate_open <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end

                S_REFUND: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fare_collector.sv
// Scoreboard bench for fare_collector: stimulus pushes expected payment
// outcomes, a monitor pops them whenever change_valid strobes and also
// tracks gate-open run lengths and coin rejects.
module tb_fare_collector;

    localparam int GATE_N  = 8;
    localparam int TOTAL_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         fare_in;
    logic               fare_valid;
    logic               coin_valid;
    logic [1:0]         coin_type;
    logic               cancel;
    logic               busy;
    logic [2:0]         state;
    logic [10:0]        paid;
    logic [10:0]        change;
    logic               change_valid;
    logic               gate_open;
    logic               coin_reject;
    logic [TOTAL_W-1:0] total_collected;

    fare_collector #(
        .GATE_CYCLES   (GATE_N),
        .TOTAL_W       (TOTAL_W),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fare_in        (fare_in),
        .fare_valid     (fare_valid),
        .coin_valid     (coin_valid),
        .coin_type      (coin_type),
        .cancel         (cancel),
        .busy           (busy),
        .state          (state),
        .paid           (paid),
        .change         (change),
        .change_valid   (change_valid),
        .gate_open      (gate_open),
        .coin_reject    (coin_reject),
        .total_collected(total_collected)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;     // 2 = change given, 4 = refund
        int amt;
        int tot;
        int pd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int total_m = 0;
    int last_paid = 0;
    int rejects_exp = 0;
    int rejects_seen = 0;
    int gates_exp = 0;
    int gates_seen = 0;
    int gate_run = 0;

    function automatic int coin_val(input int t);
        case (t)
            0: return 1;
            1: return 5;
            2: return 10;
            default: return 20;
        endcase
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (busy != (state != 3'd0)) begin
                errors++;
                $display("FAIL busy_vs_state: busy=%0b state=%0d", busy, state);
            end
            if (change_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: change=%0d state=%0d", change, state);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(state) != e.st || int'(change) != e.amt ||
                        int'(total_collected) != e.tot || int'(paid) != e.pd) begin
                        errors++;
                        $display("FAIL payment: got state=%0d change=%0d total=%0d paid=%0d, expected state=%0d change=%0d total=%0d paid=%0d",
                                 state, change, total_collected, paid, e.st, e.amt, e.tot, e.pd);
                    end
                end
            end
            if (gate_open) begin
                gate_run++;
            end else if (gate_run > 0) begin
                checks++;
                gates_seen++;
                if (gate_run != GATE_N) begin
                    errors++;
                    $display("FAIL gate_length: got %0d cycles, expected %0d", gate_run, GATE_N);
                end
                gate_run = 0;
            end
            if (coin_reject) rejects_seen++;
        end
    end

    task automatic drive(input logic fv, input logic [9:0] f, input logic cv,
                         input logic [1:0] ct, input logic cn);
        fare_valid = fv;
        fare_in    = f;
        coin_valid = cv;
        coin_type  = ct;
        cancel     = cn;
        @(posedge clk);
        #1;
        fare_valid = 1'b0;
        coin_valid = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 10'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, state=%0d", n, state);
        end
    endtask

    task automatic push_exp(input int st, input int amt, input int tot, input int pd);
        exp_t e;
        e.st = st; e.amt = amt; e.tot = tot; e.pd = pd;
        exp_q.push_back(e);
    endtask

    // One payment transaction from the driver's point of view.
    // cancel_idx: index of the coin slot carrying cancel (-1 = none); if the
    // coins run out before the fare is met, a lone cancel ends the transaction.
    task automatic txn(input int fare, input int coins[$], input int cancel_idx, input bit noise);
        int pm = 0;
        bit done = 1'b0;
        bit gave_change = 1'b0;
        wait_idle();
        if (noise) begin
            drive(1'b0, 10'd0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
            rejects_exp++;
            checks++;
            if (int'(paid) != last_paid) begin
                errors++;
                $display("FAIL paid_after_idle_coin: got %0d expected %0d", paid, last_paid);
            end
        end
        drive(1'b1, 10'(fare), 1'b0, 2'd0, 1'b0);
        last_paid = 0;
        if (fare == 0) begin
            gates_exp++;
            if (noise) begin
                idle_cycle();
                drive(1'b0, 10'd0, 1'b1, 2'd2, 1'b0);
                rejects_exp++;
            end
            wait_idle();
            return;
        end
        for (int i = 0; i < coins.size() && !done; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if (noise && ($urandom_range(0, 1) == 1))
                    drive(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 2'd0, 1'b0);
                else
                    idle_cycle();
            end
            pm += coin_val(coins[i]);
            if (i == cancel_idx) begin
                push_exp(4, pm, total_m, pm);
                done = 1'b1;
            end else if (pm >= fare) begin
                total_m = (total_m + fare) % (1 << TOTAL_W);
                push_exp(2, pm - fare, total_m, pm);
                gates_exp++;
                done = 1'b1;
                gave_change = 1'b1;
            end
            drive(1'b0, 10'd0, 1'b1, 2'(coins[i]), 1'(i == cancel_idx));
        end
        if (!done) begin
            push_exp(4, pm, total_m, pm);
            drive(1'b0, 10'd0, 1'b0, 2'd0, 1'b1);
        end
        last_paid = pm;
        if (noise && gave_change) begin
            idle_cycle();
            drive(1'b0, 10'd0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
            rejects_exp++;
        end
        wait_idle();
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (state != 3'd0 || busy || paid != 11'd0 || change != 11'd0 || change_valid ||
            gate_open || coin_reject || total_collected != '0) begin
            errors++;
            $display("FAIL %s: state=%0d busy=%0b paid=%0d change=%0d cv=%0b gate=%0b rej=%0b total=%0d, expected all zero",
                     tag, state, busy, paid, change, change_valid, gate_open, coin_reject, total_collected);
        end
    endtask

    initial begin
        int q[$];
        reset = 1'b1;
        fare_in = '0; fare_valid = 1'b0; coin_valid = 1'b0; coin_type = '0; cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("reset_state");

        q = '{3, 1};  txn(25, q, -1, 1'b0);   // exact payment, change 0, total 25
        q = '{2, 1};  txn(12, q, -1, 1'b0);   // change 3, total 37
        q = '{3, 1};  txn(30, q, 1, 1'b0);    // cancel with coin: refund 25
        q = {};       txn(0, q, -1, 1'b1);    // zero fare straight to OPEN
        q = '{2, 2};  txn(17, q, -1, 1'b1);   // rejects in IDLE and OPEN, ignored fare_valid

        for (int t = 0; t < 40; t++) begin
            int fare;
            int sum = 0;
            int cidx = -1;
            fare = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 90);
            q = {};
            while (sum < fare) begin
                int c = $urandom_range(0, 3);
                q.push_back(c);
                sum += coin_val(c);
            end
            if (q.size() > 0 && $urandom_range(0, 6) == 0) void'(q.pop_back());
            if (q.size() > 0 && $urandom_range(0, 4) == 0) cidx = $urandom_range(0, q.size() - 1);
            txn(fare, q, cidx, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of COLLECT with 15 inserted.
        wait_idle();
        drive(1'b1, 10'd40, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 10'd0, 1'b1, 2'd2, 1'b0);
        drive(1'b0, 10'd0, 1'b1, 2'd1, 1'b0);
        checks++;
        if (paid != 11'd15 || state != 3'd1) begin
            errors++;
            $display("FAIL pre_reset_paid: paid=%0d state=%0d expected paid=15 state=1", paid, state);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("mid_reset");
        total_m = 0;
        last_paid = 0;
        q = '{3, 3, 2};  txn(50, q, -1, 1'b0);   // total restarts from zero

        // Idle-coin behaviour in COLLECT.
        wait_idle();
        drive(1'b1, 10'd40, 1'b0, 2'd0, 1'b0);
        push_exp(4, 20, total_m, 20);
`ifdef PAYMENT_TIMEOUT_EN
        begin
            int n = 0;
            drive(1'b0, 10'd0, 1'b1, 2'd3, 1'b0);
            while (!change_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (n != 10) begin
                errors++;
                $display("FAIL timeout_latency: got %0d cycles, expected 10", n);
            end
        end
`else
        drive(1'b0, 10'd0, 1'b1, 2'd3, 1'b0);
        repeat (120) idle_cycle();
        checks++;
        if (state != 3'd1) begin
            errors++;
            $display("FAIL no_timeout: state=%0d after 120 idle cycles, expected 1", state);
        end
        drive(1'b0, 10'd0, 1'b0, 2'd0, 1'b1);
`endif
        last_paid = 20;
        wait_idle();
        repeat (5) idle_cycle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_payments: %0d outcomes never observed, expected 0", exp_q.size());
        end
        checks++;
        if (rejects_seen != rejects_exp) begin
            errors++;
            $display("FAIL coin_reject_count: got %0d expected %0d", rejects_seen, rejects_exp);
        end
        checks++;
        if (gates_seen != gates_exp) begin
            errors++;
            $display("FAIL gate_count: got %0d expected %0d", gates_seen, gates_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
